// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter bundle: FU result requests in, CDB broadcast out.
// Latency: n/a (wires only).
// Backpressure: req_ready per FU; the CDB side has none.
//
// Ports (signals):
//   req_valid/req_ready      per-FU handshake (0 ALU, 1 MUL, 2 DIV, 3 MEM, 4 BR)
//   req_pd/rd/rob_num/value  per-FU result payload
//   global_branch_signal     flush, drops everything pending
//   cdb_*                    registered one-cycle broadcast to ROB/RS/PRF
// Modports: master = execute-unit side, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_BITS      = 6
);
  logic [4:0]                    req_valid;
  logic [4:0]                    req_ready;
  logic [4:0][PHYS_REG_BITS-1:0] req_pd;
  logic [4:0][4:0]               req_rd;
  logic [4:0][ROB_BITS-1:0]      req_rob_num;
  logic [4:0][31:0]              req_value;
  logic                          global_branch_signal;

  logic                          cdb_valid;
  logic [PHYS_REG_BITS-1:0]      cdb_pd;
  logic [4:0]                    cdb_rd;
  logic [ROB_BITS-1:0]           cdb_rob_num;
  logic [31:0]                   cdb_value;
  logic [2:0]                    cdb_src;
  logic                          cdb_regf_we;

  modport master (
    output req_valid, req_pd, req_rd, req_rob_num, req_value, global_branch_signal,
    input  req_ready, cdb_valid, cdb_pd, cdb_rd, cdb_rob_num, cdb_value, cdb_src, cdb_regf_we
  );

  modport slave (
    input  req_valid, req_pd, req_rd, req_rob_num, req_value, global_branch_signal,
    output req_ready, cdb_valid, cdb_pd, cdb_rd, cdb_rob_num, cdb_value, cdb_src, cdb_regf_we
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding buffer per FU, one grant per cycle onto a registered CDB.
// Latency: handshake in cycle k -> cdb_valid in k+2 (minimum).
// Backpressure: req_ready[i] low while buffer i is full and not granted, and during flush.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   cdb_arbiter_if.slave (request side + CDB broadcast)
// Config macro CDB_RR_EN: defined -> round-robin arbitration,
//                         undefined -> fixed priority (ALU > MUL > DIV > MEM > BR).
module cdb_arbiter #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_BITS      = 6
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  // Holding buffers
  logic [4:0]                    full_q, full_d;
  logic [4:0][PHYS_REG_BITS-1:0] pd_q, pd_d;
  logic [4:0][4:0]               rd_q, rd_d;
  logic [4:0][ROB_BITS-1:0]      rob_q, rob_d;
  logic [4:0][31:0]              val_q, val_d;

  // CDB registers
  logic                     cdb_valid_q, cdb_valid_d;
  logic [PHYS_REG_BITS-1:0] cdb_pd_q, cdb_pd_d;
  logic [4:0]               cdb_rd_q, cdb_rd_d;
  logic [ROB_BITS-1:0]      cdb_rob_q, cdb_rob_d;
  logic [31:0]              cdb_val_q, cdb_val_d;
  logic [2:0]               cdb_src_q, cdb_src_d;

  // Arbitration results
  logic       grant_any;
  logic [2:0] grant_idx;
  logic [4:0] grant;
  logic [4:0] ready;
  logic [4:0] hs;

`ifdef CDB_RR_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] scan_idx;

  // Walk five slots starting at rr_ptr; the wrap is an explicit compare so
  // the pointer never visits 5..7.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 3'd0;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < 5; k++) begin
      if (!grant_any && !bus.global_branch_signal && full_q[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= 3'd0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  // Scan from the top down so the lowest full index is the last writer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (!bus.global_branch_signal && full_q[k]) begin
        grant_any = 1'b1;
        grant_idx = 3'(k);
      end
    end
  end
`endif

  assign grant = grant_any ? (5'b00001 << grant_idx) : 5'b00000;

  // A granted buffer may be refilled in the same cycle, giving 1/cycle per FU.
  assign ready = {5{!bus.global_branch_signal}} & (~full_q | grant);
  assign hs    = bus.req_valid & ready;

  always_comb begin
    full_d = full_q;
    pd_d   = pd_q;
    rd_d   = rd_q;
    rob_d  = rob_q;
    val_d  = val_q;
    if (bus.global_branch_signal) begin
      full_d = 5'b00000;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (grant[i]) full_d[i] = 1'b0;
        // Refill after the grant clear so new data wins.
        if (hs[i]) begin
          full_d[i] = 1'b1;
          pd_d[i]   = bus.req_pd[i];
          rd_d[i]   = bus.req_rd[i];
          rob_d[i]  = bus.req_rob_num[i];
          val_d[i]  = bus.req_value[i];
        end
      end
    end
  end

  // No grant (including the flush cycle) drops valid but holds the payload.
  always_comb begin
    cdb_valid_d = grant_any;
    cdb_pd_d    = cdb_pd_q;
    cdb_rd_d    = cdb_rd_q;
    cdb_rob_d   = cdb_rob_q;
    cdb_val_d   = cdb_val_q;
    cdb_src_d   = cdb_src_q;
    if (grant_any) begin
      cdb_pd_d  = pd_q[grant_idx];
      cdb_rd_d  = rd_q[grant_idx];
      cdb_rob_d = rob_q[grant_idx];
      cdb_val_d = val_q[grant_idx];
      cdb_src_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      pd_q        <= '0;
      rd_q        <= '0;
      rob_q       <= '0;
      val_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pd_q    <= '0;
      cdb_rd_q    <= '0;
      cdb_rob_q   <= '0;
      cdb_val_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      full_q      <= full_d;
      pd_q        <= pd_d;
      rd_q        <= rd_d;
      rob_q       <= rob_d;
      val_q       <= val_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pd_q    <= cdb_pd_d;
      cdb_rd_q    <= cdb_rd_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_val_q   <= cdb_val_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_pd      = cdb_pd_q;
  assign bus.cdb_rd      = cdb_rd_q;
  assign bus.cdb_rob_num = cdb_rob_q;
  assign bus.cdb_value   = cdb_val_q;
  assign bus.cdb_src     = cdb_src_q;
  assign bus.cdb_regf_we = cdb_valid_q && (cdb_rd_q != 5'd0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic vs. a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdb_arbiter;
  localparam int PRB = 6;
  localparam int RB  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.PHYS_REG_BITS(PRB), .ROB_BITS(RB)) bus ();

  cdb_arbiter #(.PHYS_REG_BITS(PRB), .ROB_BITS(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: buffers as plain arrays, arbitration as a modular search.
  bit            m_live = 0;
  bit            m_full [5];
  logic [PRB-1:0] m_pd  [5];
  logic [4:0]     m_rd  [5];
  logic [RB-1:0]  m_rob [5];
  logic [31:0]    m_val [5];
  int             m_ptr;
  bit             m_cv;
  logic [PRB-1:0] m_cpd;
  logic [4:0]     m_crd;
  logic [RB-1:0]  m_crob;
  logic [31:0]    m_cval;
  int             m_csrc;

  function automatic int model_grant();
    if (bus.global_branch_signal) return -1;
    for (int k = 0; k < 5; k++) begin
`ifdef CDB_RR_EN
      if (m_full[(m_ptr + k) % 5]) return (m_ptr + k) % 5;
`else
      if (m_full[k]) return k;
`endif
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_full[i] = 0; m_pd[i] = '0; m_rd[i] = '0; m_rob[i] = '0; m_val[i] = '0;
    end
    m_ptr = 0; m_cv = 0; m_cpd = '0; m_crd = '0; m_crob = '0; m_cval = '0; m_csrc = 0;
    m_live = 1;
  endtask

  // One clock: check DUT against model, then advance the model at the edge.
  task automatic tick();
    int g;
    logic [4:0] rdy;
    #1;
    g = model_grant();
    for (int i = 0; i < 5; i++)
      rdy[i] = !bus.global_branch_signal && (!m_full[i] || g == i);
    if (m_live) begin
      chk("ready", 64'(bus.req_ready), 64'(rdy));
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
      chk("cdb_pd", 64'(bus.cdb_pd), 64'(m_cpd));
      chk("cdb_rd", 64'(bus.cdb_rd), 64'(m_crd));
      chk("cdb_rob", 64'(bus.cdb_rob_num), 64'(m_crob));
      chk("cdb_value", 64'(bus.cdb_value), 64'(m_cval));
      chk("cdb_src", 64'(bus.cdb_src), 64'(m_csrc));
      chk("regf_we", 64'(bus.cdb_regf_we), 64'(m_cv && m_crd != 0));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (bus.global_branch_signal) begin
      for (int i = 0; i < 5; i++) m_full[i] = 0;
      m_cv = 0;
    end else begin
      m_cv = (g >= 0);
      if (g >= 0) begin
        m_cpd = m_pd[g]; m_crd = m_rd[g]; m_crob = m_rob[g]; m_cval = m_val[g];
        m_csrc = g; m_ptr = (g + 1) % 5; m_full[g] = 0;
      end
      for (int i = 0; i < 5; i++) begin
        if (bus.req_valid[i] && rdy[i]) begin
          m_full[i] = 1; m_pd[i] = bus.req_pd[i]; m_rd[i] = bus.req_rd[i];
          m_rob[i] = bus.req_rob_num[i]; m_val[i] = bus.req_value[i];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.global_branch_signal = 1'b0;
  endtask

  task automatic drive(input int fu, input logic [PRB-1:0] pd, input logic [4:0] rd,
                       input logic [RB-1:0] rob, input logic [31:0] val);
    bus.req_valid[fu]   = 1'b1;
    bus.req_pd[fu]      = pd;
    bus.req_rd[fu]      = rd;
    bus.req_rob_num[fu] = rob;
    bus.req_value[fu]   = val;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int br_cnt;

  initial begin
    bus.req_valid = '0; bus.req_pd = '0; bus.req_rd = '0;
    bus.req_rob_num = '0; bus.req_value = '0; bus.global_branch_signal = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset values, first cycle after reset
    #1;
    chk("rst_valid", 64'(bus.cdb_valid), 0);
    chk("rst_value", 64'(bus.cdb_value), 0);
    chk("rst_src", 64'(bus.cdb_src), 0);
    chk("rst_we", 64'(bus.cdb_regf_we), 0);
    chk("rst_ready", 64'(bus.req_ready), 64'h1f);

    // Single ALU result, 2-cycle latency, one-cycle broadcast
    drive(0, 6'd5, 5'd3, 6'd7, 32'hDEADBEEF);
    tick();
    idle();
    tick();
    chk("single_valid", 64'(bus.cdb_valid), 1);
    chk("single_pd", 64'(bus.cdb_pd), 5);
    chk("single_rd", 64'(bus.cdb_rd), 3);
    chk("single_rob", 64'(bus.cdb_rob_num), 7);
    chk("single_value", 64'(bus.cdb_value), 64'hDEADBEEF);
    chk("single_src", 64'(bus.cdb_src), 0);
    chk("single_we", 64'(bus.cdb_regf_we), 1);
    tick();
    chk("single_one_cycle", 64'(bus.cdb_valid), 0);

    // All five at once with pointer at 0: order 0..4 in both modes
    do_reset();
    for (int i = 0; i < 5; i++) drive(i, 6'(i + 10), 5'(i + 1), 6'(i + 20), 32'(100 + i));
    tick();
    idle();
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("all5_valid", 64'(bus.cdb_valid), 1);
      chk("all5_src", 64'(bus.cdb_src), 64'(j));
      chk("all5_value", 64'(bus.cdb_value), 64'(100 + j));
    end
    tick();
    chk("all5_done", 64'(bus.cdb_valid), 0);

    // ALU re-requesting every cycle alongside the others
    do_reset();
    for (int i = 0; i < 5; i++) drive(i, 6'(i), 5'(i + 1), 6'(i), 32'(200 + i));
    br_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.cdb_valid && bus.cdb_src == 3'd4) br_cnt++;
      bus.req_valid = 5'b00001;
      bus.req_value[0] = 32'(300 + c);
    end
`ifdef CDB_RR_EN
    chk("rr_br_served", 64'(br_cnt != 0), 1);
`else
    chk("starve_br", 64'(br_cnt), 0);
`endif
    idle();
    for (int c = 0; c < 8; c++) tick();

    // Back-to-back MUL through grant-plus-refill
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 6'd9, 5'd4, 6'(i), 32'(i + 1));
      else idle();
      #1;
      if (i < 4) chk("b2b_ready", 64'(bus.req_ready[1]), 1);
      tick();
      if (i >= 1 && i <= 4) begin
        chk("b2b_valid", 64'(bus.cdb_valid), 1);
        chk("b2b_value", 64'(bus.cdb_value), 64'(i));
      end
    end

    // Flush in the cycle DIV/MEM would be granted
    do_reset();
    drive(2, 6'd1, 5'd1, 6'd1, 32'h11);
    drive(3, 6'd2, 5'd2, 6'd2, 32'h22);
    tick();
    idle();
    drive(0, 6'd3, 5'd3, 6'd3, 32'h33);
    bus.global_branch_signal = 1'b1;
    tick();
    idle();
    chk("flush_valid", 64'(bus.cdb_valid), 0);
    #1;
    chk("flush_ready", 64'(bus.req_ready), 64'h1f);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("flush_stale", 64'(bus.cdb_valid), 0);
    end

    // Reset in the middle of traffic
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 6'(i + 1), 5'(i + 1), 6'(i + 1), 32'(i + 50));
    tick();
    idle();
    tick();
    chk("mid_pre_valid", 64'(bus.cdb_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 64'(bus.cdb_valid), 0);
    chk("mid_value", 64'(bus.cdb_value), 0);
    chk("mid_pd", 64'(bus.cdb_pd), 0);
    chk("mid_src", 64'(bus.cdb_src), 0);
    chk("mid_we", 64'(bus.cdb_regf_we), 0);
    #1;
    chk("mid_ready", 64'(bus.req_ready), 64'h1f);
    drive(0, 6'd8, 5'd8, 6'd8, 32'h88);
    tick();
    idle();
    tick();
    chk("mid_new_valid", 64'(bus.cdb_valid), 1);
    chk("mid_new_value", 64'(bus.cdb_value), 64'h88);

    // BR result writing x0
    do_reset();
    drive(4, 6'd12, 5'd0, 6'd13, 32'h1234);
    tick();
    idle();
    tick();
    chk("rd0_valid", 64'(bus.cdb_valid), 1);
    chk("rd0_src", 64'(bus.cdb_src), 4);
    chk("rd0_we", 64'(bus.cdb_regf_we), 0);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = 5'($urandom_range(0, 31));
      for (int i = 0; i < 5; i++) begin
        bus.req_pd[i]      = 6'($urandom_range(0, 63));
        bus.req_rd[i]      = 5'($urandom_range(0, 31));
        bus.req_rob_num[i] = 6'($urandom_range(0, 63));
        bus.req_value[i]   = $urandom;
      end
      bus.global_branch_signal = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    for (int c = 0; c < 8; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
